// File: rtl/sipo_rx.sv
// sipo_rx: LSB-first serial-to-parallel receiver with a one-entry valid/ready holding buffer.
// Latency: po_valid rises one clock after the si_en cycle carrying the last bit of a frame.
// Backpressure: a word completing while the buffer is full and not draining is dropped and sets sticky overrun.
// Optional feature macro: SIPO_RX_PARITY_EN (adds one even-parity bit per frame and drives parity_err).
// WIDTH must be at least 2; WIDTH=1 is not supported.

module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si,
  input  logic             si_en,
  input  logic             start,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             busy,
  output logic             parity_err
);

`ifdef SIPO_RX_PARITY_EN
  // Data bits plus one trailing even-parity bit per frame.
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [CW-1:0]    cnt;

  logic [NBITS-1:0] frame_nxt;
  logic             take_start;
  logic             take_bit;
  logic             complete;
  logic             load;
  logic             drop;

  // New bits enter at the top, so the first bit of a frame lands in bit 0 once the frame is full.
  assign frame_nxt  = {si, shreg[NBITS-1:1]};
  // A qualified start always wins, in IDLE as well as mid-frame (silent abort).
  assign take_start = si_en & start;
  assign take_bit   = si_en & ~start & (state == SHIFT);
  // Start sets the counter to 1, so the last bit arrives while cnt == NBITS-1.
  assign complete   = take_bit & (cnt == CW'(NBITS - 1));
  // Refill is allowed when the buffer is empty or is being drained in this same cycle.
  assign load       = complete & (~po_valid | po_ready);
  assign drop       = complete & po_valid & ~po_ready;

  assign busy = (state == SHIFT);

  // Frame FSM: shift register and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (take_start) begin
      state <= SHIFT;
      shreg <= {si, {(NBITS-1){1'b0}}};
      cnt   <= CW'(1);
    end else if (take_bit) begin
      shreg <= frame_nxt;
      if (complete) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt   <= cnt + CW'(1);
      end
    end
  end

  // Holding buffer: load on completion when there is room, clear on a handshake otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      po       <= '0;
      po_valid <= 1'b0;
    end else if (load) begin
      po       <= frame_nxt[WIDTH-1:0];
      po_valid <= 1'b1;
    end else if (po_valid && po_ready) begin
      po_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef SIPO_RX_PARITY_EN
  // Parity status travels with the word: loaded, held and dropped exactly like po.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= ^frame_nxt;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
